// File: rtl/shift_counter_pkg.sv
// rtl/shift_counter_pkg.sv - shared constants, FSM encoding and width helper
// Purpose: definitions shared by the shift-counter decoder and its code-to-index
// sub-module.
package shift_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // A Johnson counter of width n has 2n states; ring needs only n.
  function automatic int idx_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/shift_code_to_index.sv
// rtl/shift_code_to_index.sv - combinational ring/Johnson legality check and decode
// Purpose: classify one code word and decode it to its position in the sequence.
// Ports:
//   mode  in   0 = ring, 1 = Johnson
//   code  in   N-bit code word
//   legal out  code word belongs to the selected sequence
//   idx   out  decoded position (only meaningful when legal)
module shift_code_to_index
  import shift_counter_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = idx_width(N)
) (
  input  logic            mode,
  input  logic [N-1:0]    code,
  output logic            legal,
  output logic [IDXW-1:0] idx
);

  localparam logic [N-1:0] ONES = '1;

  int pop;
  int pos;

  always_comb begin
    pop   = 0;
    pos   = 0;
    legal = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (code[i]) begin
        pop = pop + 1;
        pos = i;
      end
    end
    if (mode == MODE_RING) begin
      legal = (pop == 1);
      idx   = IDXW'(pos);
    end else if (!code[N-1]) begin
      // Filling half: p low ones, i.e. (1<<p)-1.
      legal = (code == ~(ONES << pop));
      idx   = IDXW'(pop);
    end else begin
      // Draining half: p high ones, i.e. all-ones shifted left by N-p.
      legal = (code == (ONES << (N - pop)));
      idx   = IDXW'(2 * N - pop);
    end
  end

endmodule

// File: rtl/shift_counter_decoder.sv
// rtl/shift_counter_decoder.sv - ring/Johnson code checker with lock FSM and error count
// Purpose: decode each valid sample, check legality and successor order, track lock.
// Ports:
//   clk         in   rising-edge clock
//   start       in   synchronous active-high reset
//   mode        in   0 = ring, 1 = Johnson
//   code_valid  in   code_in is sampled this cycle
//   code_in     in   N-bit code word
//   clr_err     in   synchronous clear of err_count
//   index       out  decoded position of the last legal sample
//   index_valid out  pulse: index updated
//   code_err    out  pulse: illegal code sampled
//   seq_err     out  pulse: legal code that is not the expected successor
//   locked      out  FSM is in LOCKED
//   err_count   out  saturating count of code_err + seq_err
module shift_counter_decoder
  import shift_counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDXW     = idx_width(N),
  parameter int LOCK_CNT = 4
) (
  input  logic            clk,
  input  logic            start,
  input  logic            mode,
  input  logic            code_valid,
  input  logic [N-1:0]    code_in,
  input  logic            clr_err,
  output logic [IDXW-1:0] index,
  output logic            index_valid,
  output logic            code_err,
  output logic            seq_err,
  output logic            locked,
  output logic [7:0]      err_count
);

  localparam int RUNW = $clog2(LOCK_CNT + 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] prev_q, prev_d, index_d, succ;
  logic [RUNW-1:0] run_q, run_d;
  logic            mode_q;
  logic            iv_d, ce_d, se_d, err_ev;
  logic            dec_legal;
  logic [IDXW-1:0] dec_idx;

  shift_code_to_index #(.N(N), .IDXW(IDXW)) u_dec (
    .mode  (mode),
    .code  (code_in),
    .legal (dec_legal),
    .idx   (dec_idx)
  );

  always_comb begin
    if (mode == MODE_JOHNSON) succ = IDXW'((int'(prev_q) + 1) % (2 * N));
    else                      succ = IDXW'((int'(prev_q) + 1) % N);
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    index_d = index;
    iv_d    = 1'b0;
    ce_d    = 1'b0;
    se_d    = 1'b0;
    if (mode != mode_q) begin
      // Mode switch silently restarts acquisition; the sample is discarded.
      state_d = HUNT;
      run_d   = '0;
    end else if (code_valid) begin
      if (!dec_legal) begin
        ce_d    = 1'b1;
        state_d = HUNT;
        run_d   = '0;
      end else begin
        iv_d    = 1'b1;
        index_d = dec_idx;
        prev_d  = dec_idx;
        case (state_q)
          HUNT: begin
            run_d   = '0;
            state_d = TRACK;
          end
          TRACK, LOCKED: begin
            if (dec_idx != succ) begin
              se_d    = 1'b1;
              run_d   = '0;
              state_d = TRACK;
            end else if (state_q == TRACK) begin
              run_d = run_q + 1'b1;
              if (run_q == RUNW'(LOCK_CNT - 1)) state_d = LOCKED;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  assign err_ev = ce_d | se_d;

  always_ff @(posedge clk) begin
    if (start) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      run_q       <= '0;
      mode_q      <= mode;
      index       <= '0;
      index_valid <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      mode_q      <= mode;
      index       <= index_d;
      index_valid <= iv_d;
      code_err    <= ce_d;
      seq_err     <= se_d;
      locked      <= (state_d == LOCKED);
      if (clr_err)                           err_count <= {7'd0, err_ev};
      else if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_shift_counter_decoder.sv
// tb/tb_shift_counter_decoder.sv - directed scoreboard bench for shift_counter_decoder
module tb_shift_counter_decoder;

  logic       clk = 1'b0;
  logic       start = 1'b1;
  logic       mode = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code_in = 4'd0;
  logic       clr_err = 1'b0;
  logic [2:0] index;
  logic       index_valid, code_err, seq_err, locked;
  logic [7:0] err_count;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [2:0] idx;
    logic       iv, ce, se, lk;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  shift_counter_decoder #(.N(4), .IDXW(3), .LOCK_CNT(4)) dut (
    .clk         (clk),
    .start       (start),
    .mode        (mode),
    .code_valid  (code_valid),
    .code_in     (code_in),
    .clr_err     (clr_err),
    .index       (index),
    .index_valid (index_valid),
    .code_err    (code_err),
    .seq_err     (seq_err),
    .locked      (locked),
    .err_count   (err_count)
  );

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    cmp({e.tag, ".index"}, {5'd0, index}, {5'd0, e.idx});
    cmp({e.tag, ".index_valid"}, {7'd0, index_valid}, {7'd0, e.iv});
    cmp({e.tag, ".code_err"}, {7'd0, code_err}, {7'd0, e.ce});
    cmp({e.tag, ".seq_err"}, {7'd0, seq_err}, {7'd0, e.se});
    cmp({e.tag, ".locked"}, {7'd0, locked}, {7'd0, e.lk});
    cmp({e.tag, ".err_count"}, err_count, e.ec);
  endtask

  // Drive one cycle of stimulus, queue its expected result, sample 1 time unit after the edge.
  task automatic step(input string tag, input logic v, input logic [3:0] c,
                      input logic [2:0] idx, input logic iv, input logic ce,
                      input logic se, input logic lk, input logic [7:0] ec);
    exp_t e;
    code_valid = v;
    code_in    = c;
    e.tag = tag; e.idx = idx; e.iv = iv; e.ce = ce; e.se = se; e.lk = lk; e.ec = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset in ring mode
    start = 1'b1;
    step("rst0", 1'b0, 4'b0000, 3'd0, 0, 0, 0, 0, 8'd0);
    start = 1'b0;

    // Ring lock
    step("ring0", 1'b1, 4'b0001, 3'd0, 1, 0, 0, 0, 8'd0);
    step("ring1", 1'b1, 4'b0010, 3'd1, 1, 0, 0, 0, 8'd0);
    step("ring2", 1'b1, 4'b0100, 3'd2, 1, 0, 0, 0, 8'd0);
    step("ring3", 1'b1, 4'b1000, 3'd3, 1, 0, 0, 0, 8'd0);
    step("ring4", 1'b1, 4'b0001, 3'd0, 1, 0, 0, 1, 8'd0);
    // Illegal while locked: index held
    step("ring_ill", 1'b1, 4'b0011, 3'd0, 0, 1, 0, 0, 8'd1);
    step("idle", 1'b0, 4'b0100, 3'd0, 0, 0, 0, 0, 8'd1);

    // Johnson full cycle after reset in Johnson mode
    mode  = 1'b1;
    start = 1'b1;
    step("rst1", 1'b1, 4'b0001, 3'd0, 0, 0, 0, 0, 8'd0);
    start = 1'b0;
    step("j0", 1'b1, 4'b0000, 3'd0, 1, 0, 0, 0, 8'd0);
    step("j1", 1'b1, 4'b0001, 3'd1, 1, 0, 0, 0, 8'd0);
    step("j2", 1'b1, 4'b0011, 3'd2, 1, 0, 0, 0, 8'd0);
    step("j3", 1'b1, 4'b0111, 3'd3, 1, 0, 0, 0, 8'd0);
    step("j4", 1'b1, 4'b1111, 3'd4, 1, 0, 0, 1, 8'd0);
    step("j5", 1'b1, 4'b1110, 3'd5, 1, 0, 0, 1, 8'd0);
    step("j6", 1'b1, 4'b1100, 3'd6, 1, 0, 0, 1, 8'd0);
    step("j7", 1'b1, 4'b1000, 3'd7, 1, 0, 0, 1, 8'd0);
    step("jwrap", 1'b1, 4'b0000, 3'd0, 1, 0, 0, 1, 8'd0);
    step("jw1", 1'b1, 4'b0001, 3'd1, 1, 0, 0, 1, 8'd0);
    step("jw2", 1'b1, 4'b0011, 3'd2, 1, 0, 0, 1, 8'd0);
    // Sequence break and relock
    step("jbrk", 1'b1, 4'b1111, 3'd4, 1, 0, 1, 0, 8'd1);
    step("jr5", 1'b1, 4'b1110, 3'd5, 1, 0, 0, 0, 8'd1);
    step("jr6", 1'b1, 4'b1100, 3'd6, 1, 0, 0, 0, 8'd1);
    step("jr7", 1'b1, 4'b1000, 3'd7, 1, 0, 0, 0, 8'd1);
    step("jr0", 1'b1, 4'b0000, 3'd0, 1, 0, 0, 1, 8'd1);
    // Johnson illegal code while locked
    step("j_ill", 1'b1, 4'b0101, 3'd0, 0, 1, 0, 0, 8'd2);
    // Repeated code is a sequence error
    step("jh1", 1'b1, 4'b0001, 3'd1, 1, 0, 0, 0, 8'd2);
    step("jrep", 1'b1, 4'b0001, 3'd1, 1, 0, 1, 0, 8'd3);
    step("jl2", 1'b1, 4'b0011, 3'd2, 1, 0, 0, 0, 8'd3);
    step("jl3", 1'b1, 4'b0111, 3'd3, 1, 0, 0, 0, 8'd3);
    step("jl4", 1'b1, 4'b1111, 3'd4, 1, 0, 0, 0, 8'd3);
    step("jl5", 1'b1, 4'b1110, 3'd5, 1, 0, 0, 1, 8'd3);

    // Mode toggle while locked: sample dropped, no error, back to HUNT
    mode = 1'b0;
    step("mtog", 1'b1, 4'b0001, 3'd5, 0, 0, 0, 0, 8'd3);
    step("mpost", 1'b1, 4'b0010, 3'd1, 1, 0, 0, 0, 8'd3);

    // Saturation
    for (int k = 1; k <= 300; k++) begin
      step("sat", 1'b1, 4'b0000, 3'd1, 0, 1, 0, 0,
           (3 + k > 255) ? 8'd255 : 8'(3 + k));
    end
    clr_err = 1'b1;
    step("clr_err_ev", 1'b1, 4'b0000, 3'd1, 0, 1, 0, 0, 8'd1);
    step("clr_only", 1'b0, 4'b0000, 3'd1, 0, 0, 0, 0, 8'd0);
    clr_err = 1'b0;

    // Relock, then reset mid-lock
    step("rl0", 1'b1, 4'b0001, 3'd0, 1, 0, 0, 0, 8'd0);
    step("rl1", 1'b1, 4'b0010, 3'd1, 1, 0, 0, 0, 8'd0);
    step("rl2", 1'b1, 4'b0100, 3'd2, 1, 0, 0, 0, 8'd0);
    step("rl3", 1'b1, 4'b1000, 3'd3, 1, 0, 0, 0, 8'd0);
    step("rl4", 1'b1, 4'b0001, 3'd0, 1, 0, 0, 1, 8'd0);
    start = 1'b1;
    step("rst_lock", 1'b1, 4'b0010, 3'd0, 0, 0, 0, 0, 8'd0);
    start = 1'b0;
    step("post_rst", 1'b1, 4'b0100, 3'd2, 1, 0, 0, 0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
